// File: rtl/pio_arb_pkg.sv
// Shared types and defaults for the two-requester PIO access arbiter.
package pio_arb_pkg;
  localparam int PIO_DATA_W = 32;
  localparam int PIO_ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } pio_state_e;
endpackage

// File: rtl/pio_arb_rr2.sv
// 2-way round-robin picker: a lone requester wins, a tie goes to the pointer.
module pio_arb_rr2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant
);
  assign grant = (req == 2'b11) ? ptr : req[1];
endmodule

// File: rtl/pio_access_arbiter.sv
// Serialises two requesters onto one PIO slave: one-cycle ISSUE, then a one-cycle ACK pulse.
module pio_access_arbiter
  import pio_arb_pkg::*;
#(
  parameter int DATA_W = PIO_DATA_W,
  parameter int ADDR_W = PIO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [DATA_W-1:0] pio_writedata,
  input  logic [DATA_W-1:0] pio_readdata
);
  pio_state_e        state, state_n;
  logic              ptr;
  logic              grant;
  logic              lat_we;
  logic              lat_idx;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              take;

  pio_arb_rr2 u_rr (
    .req   ({req1, req0}),
    .ptr   (ptr),
    .grant (grant)
  );

  assign take = (state == IDLE) && (req0 || req1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n        = state;
    ack0           = 1'b0;
    ack1           = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_address    = '0;
    pio_writedata  = '0;
    case (state)
      IDLE:  if (take) state_n = ISSUE;
      ISSUE: begin
        state_n        = ACK;
        pio_chipselect = 1'b1;
        pio_write_n    = ~lat_we;
        pio_address    = lat_addr;
        pio_writedata  = lat_wdata;
      end
      ACK: begin
        state_n = IDLE;
        ack0    = ~lat_idx;
        ack1    = lat_idx;
      end
      default: state_n = IDLE;
    endcase
  end

  // Command is captured only on the grant edge; requester changes afterwards are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= 1'b0;
      lat_we    <= 1'b0;
      lat_idx   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (take) begin
        ptr       <= ~grant;
        lat_idx   <= grant;
        lat_we    <= grant ? we1    : we0;
        lat_addr  <= grant ? addr1  : addr0;
        lat_wdata <= grant ? wdata1 : wdata0;
      end
      if (state == ISSUE && !lat_we) rdata_q <= pio_readdata;
    end
  end

  assign rdata = rdata_q;
  assign busy  = (state != IDLE);
endmodule
